// File: rtl/d_ff2.sv
`timescale 1ns/1ps
// Rising-edge D flop with asynchronous active-low reset to RST_VAL; one CK edge of latency.
// No flow control: D is captured unconditionally on every active edge while RB is high.
module d_ff2 #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CK,
  input  logic             RB,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = D;
  end

  // Reset is in the sensitivity list so RB low overrides Q without waiting for CK.
  always_ff @(posedge CK or negedge RB) begin
    if (!RB) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

// File: tb/tb_d_ff2.sv
`timescale 1ns/1ps
// Directed bench for d_ff2: a 1-bit default instance and an 8-bit instance with RST_VAL=8'hA5.
module tb_d_ff2;

  logic       ck;
  logic       rb;
  logic       d1;
  logic       q1;
  logic [7:0] d8;
  logic [7:0] q8;

  int checks   = 0;
  int failures = 0;

  d_ff2 u_dut1 (
    .CK (ck),
    .RB (rb),
    .D  (d1),
    .Q  (q1)
  );

  d_ff2 #(
    .WIDTH   (8),
    .RST_VAL (8'hA5)
  ) u_dut8 (
    .CK (ck),
    .RB (rb),
    .D  (d8),
    .Q  (q8)
  );

  // Rising edges at 10, 30, 50, ... ns
  initial begin
    ck = 1'b0;
    forever #10 ck = ~ck;
  end

  task automatic at(input int t);
    if (t > $time) #(t - $time);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  initial begin
    rb = 1'b1;
    d1 = 1'b0;
    d8 = 8'h3C;

    // Genuine falling RB edge between clock edges
    at(1);   rb = 1'b0;
    at(2);   check("rst_async_q1", {7'b0, q1}, 8'h00);
             check("rst_async_q8", q8, 8'hA5);
    at(11);  check("rst_edge10_q1", {7'b0, q1}, 8'h00);
             check("rst_edge10_q8", q8, 8'hA5);
    at(20);  d1 = 1'b1;
    at(31);  check("rst_edge30_q1", {7'b0, q1}, 8'h00);
    at(40);  d1 = 1'b0;
    at(51);  check("rst_edge50_q1", {7'b0, q1}, 8'h00);
             check("rst_edge50_q8", q8, 8'hA5);

    // Release: no change until the next rising edge
    at(60);  rb = 1'b1;
    at(61);  check("release_q1", {7'b0, q1}, 8'h00);
             check("release_q8", q8, 8'hA5);
    at(71);  check("edge70_q1", {7'b0, q1}, 8'h00);
             check("edge70_q8", q8, 8'h3C);
    at(85);  d1 = 1'b1;
    at(89);  check("pre_edge90_q1", {7'b0, q1}, 8'h00);
    at(91);  check("edge90_q1", {7'b0, q1}, 8'h01);
    at(100); d8 = 8'h5A;
    at(105); d1 = 1'b0;
    at(111); check("edge110_q1", {7'b0, q1}, 8'h00);
             check("edge110_q8", q8, 8'h5A);

    // Hold between edges
    at(135); d1 = 1'b1;
    at(145); check("pre_edge150_q1", {7'b0, q1}, 8'h00);
    at(151); check("edge150_q1", {7'b0, q1}, 8'h01);
    at(155); d1 = 1'b0;
    at(165); check("hold_mid_q1", {7'b0, q1}, 8'h01);
    at(171); check("edge170_q1", {7'b0, q1}, 8'h00);

    // Sub-cycle pulse must not be captured
    at(175); d1 = 1'b1;
    at(180); check("pulse_mid_q1", {7'b0, q1}, 8'h00);
    at(185); d1 = 1'b0;
    at(191); check("pulse_edge190_q1", {7'b0, q1}, 8'h00);

    // Asynchronous reset mid-cycle with Q=1
    at(195); d1 = 1'b1;
    at(211); check("edge210_q1", {7'b0, q1}, 8'h01);
    at(215); rb = 1'b0;
    at(216); check("midcycle_rst_q1", {7'b0, q1}, 8'h00);
             check("midcycle_rst_q8", q8, 8'hA5);
    at(231); check("rst_edge230_q1", {7'b0, q1}, 8'h00);
    at(235); rb = 1'b1;
    at(236); check("release2_q1", {7'b0, q1}, 8'h00);
    at(240); d8 = 8'hC3;
    at(249); check("pre_edge250_q8", q8, 8'hA5);
    at(251); check("edge250_q1", {7'b0, q1}, 8'h01);
             check("edge250_q8", q8, 8'hC3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
